// File: rtl/axis_in_fwft_fifo.sv
// AXI4-Stream slave front end: buffers DMA beats in a small first-word-fall-through FIFO
// and presents the head entry to the conv core on the isif_* read port.
module axis_in_fwft_fifo #(
    parameter int TBITS = 64,
    parameter int TBYTE = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             TVALID,
    output logic             TREADY,
    input  logic [TBITS-1:0] TDATA,
    input  logic [TBYTE-1:0] TKEEP,
    input  logic             TLAST,
    input  logic             TUSER,
    output logic [TBITS-1:0] isif_data_dout,
    output logic [TBYTE-1:0] isif_strb_dout,
    output logic             isif_last_dout,
    output logic             isif_user_dout,
    output logic             isif_empty_n,
    input  logic             isif_read,
    output logic [AW:0]      isif_level,
    output logic [15:0]      pkt_cnt
);
    localparam int          EW   = TBITS + TBYTE + 2;
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [1:0]    rst_sync;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   level, level_nxt;
    logic [EW-1:0] head;
    logic          push, pop, run;

    // Assertion is immediate; release is seen by the datapath only after two edges.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) rst_sync <= '0;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end

    assign run  = rst_sync[1];
    assign push = TVALID & TREADY & run;
    assign pop  = isif_read & isif_empty_n & run;
    assign head = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (push && !pop)      level_nxt = level + 1'b1;
        else if (pop && !push) level_nxt = level - 1'b1;
    end

    always_ff @(posedge aclk) begin
        if (push) mem[wr_ptr] <= {TUSER, TLAST, TKEEP, TDATA};
    end

    // TREADY tracks rst_sync[0] so it rises on the same edge the synchronizer releases.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            pkt_cnt      <= '0;
            TREADY       <= 1'b0;
            isif_empty_n <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (head[EW-2]) pkt_cnt <= pkt_cnt + 1'b1;
            end
            level        <= level_nxt;
            TREADY       <= rst_sync[0] & (level_nxt < FULL);
            isif_empty_n <= (level_nxt != '0);
        end
    end

    // Memory is never reset, so mask the head while nothing valid is stored.
    assign isif_data_dout = isif_empty_n ? head[TBITS-1:0]      : '0;
    assign isif_strb_dout = isif_empty_n ? head[TBITS +: TBYTE] : '0;
    assign isif_last_dout = isif_empty_n & head[EW-2];
    assign isif_user_dout = isif_empty_n & head[EW-1];
    assign isif_level     = level;

endmodule

// File: tb/tb_axis_in_fwft_fifo.sv
// Scoreboard bench for axis_in_fwft_fifo: accepted beats queue expected head entries,
// a negedge monitor checks every pop, the occupancy and the ready flag.
module tb_axis_in_fwft_fifo;
    localparam int TBITS = 64;
    localparam int TBYTE = 8;
    localparam int DEPTH = 4;
    localparam int AW    = 2;
    localparam int EW    = TBITS + TBYTE + 2;

    logic             aclk = 1'b0;
    logic             aresetn = 1'b0;
    logic             TVALID = 1'b0;
    logic             TREADY;
    logic [TBITS-1:0] TDATA = '0;
    logic [TBYTE-1:0] TKEEP = '0;
    logic             TLAST = 1'b0;
    logic             TUSER = 1'b0;
    logic [TBITS-1:0] isif_data_dout;
    logic [TBYTE-1:0] isif_strb_dout;
    logic             isif_last_dout;
    logic             isif_user_dout;
    logic             isif_empty_n;
    logic             isif_read = 1'b0;
    logic [AW:0]      isif_level;
    logic [15:0]      pkt_cnt;

    int               tests = 0;
    int               fails = 0;
    logic [EW-1:0]    exp_q[$];
    logic [TBITS-1:0] pop_log[$];
    logic [EW-1:0]    mon_e;
    bit               rdy_chk = 1'b0;
    bit               ok;

    always #5 aclk = ~aclk;

    axis_in_fwft_fifo #(.TBITS(TBITS), .TBYTE(TBYTE), .DEPTH(DEPTH)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .TVALID(TVALID), .TREADY(TREADY), .TDATA(TDATA), .TKEEP(TKEEP),
        .TLAST(TLAST), .TUSER(TUSER),
        .isif_data_dout(isif_data_dout), .isif_strb_dout(isif_strb_dout),
        .isif_last_dout(isif_last_dout), .isif_user_dout(isif_user_dout),
        .isif_empty_n(isif_empty_n), .isif_read(isif_read),
        .isif_level(isif_level), .pkt_cnt(pkt_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare state against the scoreboard, then retire pops and record pushes.
    always @(negedge aclk) begin
        if (!aresetn) begin
            exp_q.delete();
        end else begin
            chk("level", 64'(isif_level), 64'(exp_q.size()));
            chk("empty_n", 64'(isif_empty_n), 64'(exp_q.size() != 0));
            if (rdy_chk) chk("tready", 64'(TREADY), 64'(exp_q.size() < DEPTH));
            if (!isif_empty_n) chk("dout_idle", isif_data_dout, 64'h0);
            if (isif_read && isif_empty_n) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL pop_underflow: got data 0x%0h expected no entry at %0t",
                             isif_data_dout, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("data", isif_data_dout, mon_e[TBITS-1:0]);
                    chk("strb", 64'(isif_strb_dout), 64'(mon_e[TBITS +: TBYTE]));
                    chk("last", 64'(isif_last_dout), 64'(mon_e[EW-2]));
                    chk("user", 64'(isif_user_dout), 64'(mon_e[EW-1]));
                    pop_log.push_back(isif_data_dout);
                end
            end
            if (TVALID && TREADY) exp_q.push_back({TUSER, TLAST, TKEEP, TDATA});
        end
    end

    // Presents one beat and holds it until accepted or the budget runs out; TVALID stays high.
    task automatic send(input logic [63:0] d, input logic [7:0] k, input logic l, input logic u,
                        input int budget, output bit acc);
        TVALID = 1'b1;
        TDATA  = d;
        TKEEP  = k;
        TLAST  = l;
        TUSER  = u;
        acc    = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge aclk);
            if (TREADY) acc = 1'b1;
            @(posedge aclk);
            #1;
            if (acc) break;
        end
    endtask

    task automatic wait_empty(input int budget);
        bit done;
        done = 1'b0;
        for (int c = 0; c < budget && !done; c++) begin
            @(negedge aclk);
            if (!isif_empty_n) done = 1'b1;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: level %0d after %0d cycles, required 0", isif_level, budget);
        end
        @(posedge aclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset with TVALID asserted, then release and watch TREADY come up.
        TVALID = 1'b1;
        TDATA  = 64'hDEAD;
        repeat (3) @(negedge aclk);
        chk("rst_tready", 64'(TREADY), 64'h0);
        chk("rst_empty_n", 64'(isif_empty_n), 64'h0);
        chk("rst_level", 64'(isif_level), 64'h0);
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'h0);
        chk("rst_dout", isif_data_dout, 64'h0);
        TVALID = 1'b0;
        #2 aresetn = 1'b1;
        @(posedge aclk); #1;
        chk("tready_edge1", 64'(TREADY), 64'h0);
        @(posedge aclk); #1;
        chk("tready_edge2", 64'(TREADY), 64'h1);
        rdy_chk = 1'b1;

        // 2: fill with six beats and no reads: four accepted, then backpressure.
        for (int i = 0; i < 4; i++) begin
            send(64'h10 + 64'(i), 8'hFF, 1'b0, 1'b0, 2, ok);
            chk("fill_accept", 64'(ok), 64'h1);
        end
        send(64'h14, 8'hFF, 1'b0, 1'b0, 3, ok);
        chk("full_blocks", 64'(ok), 64'h0);
        @(negedge aclk);
        chk("full_tready", 64'(TREADY), 64'h0);
        chk("full_level", 64'(isif_level), 64'h4);
        chk("full_head", isif_data_dout, 64'h10);
        @(posedge aclk); #1;

        // 3: drain from full; the stalled beat and the sixth one go in as room opens.
        isif_read = 1'b1;
        send(64'h14, 8'hFF, 1'b0, 1'b0, 4, ok);
        chk("drain_accept5", 64'(ok), 64'h1);
        send(64'h15, 8'hFF, 1'b0, 1'b0, 2, ok);
        chk("drain_accept6", 64'(ok), 64'h1);
        TVALID = 1'b0;
        wait_empty(10);
        chk("drain_count", 64'(pop_log.size()), 64'h6);
        for (int i = 0; i < 6 && i < pop_log.size(); i++)
            chk("drain_order", pop_log[i], 64'h10 + 64'(i));
        // Reads keep going on an empty FIFO here; the monitor covers the underflow case.
        repeat (3) @(posedge aclk);
        #1;
        chk("idle_level", 64'(isif_level), 64'h0);

        // 4: 100-beat stream with the core reading every cycle.
        pop_log.delete();
        for (int i = 0; i < 100; i++) begin
            send(64'h100 + 64'(i), 8'hFF, 1'b0, 1'b0, (i == 0) ? 3 : 1, ok);
            chk("stream_accept", 64'(ok), 64'h1);
            chk("stream_level", 64'(isif_level), 64'h1);
        end
        TVALID = 1'b0;
        wait_empty(5);
        chk("stream_pops", 64'(pop_log.size()), 64'd100);

        // 5: three 5-beat packets, TUSER on the first beat, TKEEP=0x0F on the last.
        for (int p = 0; p < 3; p++) begin
            for (int b = 0; b < 5; b++) begin
                send(64'h5000 + 64'(p * 16 + b), (b == 4) ? 8'h0F : 8'hFF, b == 4, b == 0, 3, ok);
                chk("pkt_accept", 64'(ok), 64'h1);
            end
        end
        TVALID = 1'b0;
        wait_empty(10);
        chk("pkt_cnt_3", 64'(pkt_cnt), 64'h3);

        // 6: reads on empty, then async reset in the middle of a packet.
        repeat (3) @(posedge aclk);
        #1;
        chk("empty_read_level", 64'(isif_level), 64'h0);
        chk("empty_read_pkt", 64'(pkt_cnt), 64'h3);
        isif_read = 1'b0;
        send(64'hA0, 8'hFF, 1'b0, 1'b1, 2, ok);
        send(64'hA1, 8'hFF, 1'b0, 1'b0, 2, ok);
        chk("midpkt_level", 64'(isif_level), 64'h2);
        #2;
        rdy_chk = 1'b0;
        aresetn = 1'b0;
        TVALID  = 1'b0;
        #1;
        chk("async_tready", 64'(TREADY), 64'h0);
        chk("async_empty_n", 64'(isif_empty_n), 64'h0);
        chk("async_level", 64'(isif_level), 64'h0);
        chk("async_pkt_cnt", 64'(pkt_cnt), 64'h0);
        @(negedge aclk);
        #2 aresetn = 1'b1;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        chk("rerst_tready", 64'(TREADY), 64'h1);
        rdy_chk   = 1'b1;
        isif_read = 1'b1;
        send(64'hB0, 8'hFF, 1'b0, 1'b1, 2, ok);
        send(64'hB1, 8'h03, 1'b1, 1'b0, 2, ok);
        TVALID = 1'b0;
        wait_empty(10);
        chk("restart_pkt_cnt", 64'(pkt_cnt), 64'h1);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
